// File: rtl/tictac_pkg.sv
// Shared types and helpers for the tic-tac-toe game sequencer.
package tictac_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StTurn,
      StApply,
      StCheck,
      StFin
   } estado_fsm_e;

   localparam logic [1:0] EST_JUGANDO = 2'b00;
   localparam logic [1:0] EST_GANA_X  = 2'b01;
   localparam logic [1:0] EST_GANA_O  = 2'b10;
   localparam logic [1:0] EST_EMPATE  = 2'b11;

   localparam int unsigned NUM_CELDAS = 9;

   // Returns NUM_CELDAS when the board is full.
   function automatic logic [3:0] primera_libre(input logic [8:0] ocupado);
      logic [3:0] idx;
      idx = 4'(NUM_CELDAS);
      for (int i = int'(NUM_CELDAS) - 1; i >= 0; i--) begin
         if (!ocupado[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/temporizador_turno.sv
// Per-turn cycle counter; expira_o is high on the Limite-th enabled cycle after a clear.
module temporizador_turno #(
   parameter int unsigned Limite = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expira_o
);

   localparam int unsigned Ancho = (Limite > 1) ? $clog2(Limite) : 1;
   localparam logic [Ancho-1:0] Ultimo = Ancho'(Limite - 1);

   logic [Ancho-1:0] cuenta_q, cuenta_d;

   assign expira_o = (cuenta_q == Ultimo);

   // Saturates at expiry so a non-power-of-two limit never wraps.
   always_comb begin
      cuenta_d = cuenta_q;
      if (clr_i) begin
         cuenta_d = '0;
      end else if (en_i && !expira_o) begin
         cuenta_d = cuenta_q + Ancho'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cuenta_q <= '0;
      else       cuenta_q <= cuenta_d;
   end

endmodule

// File: rtl/control_turnos.sv
// Tic-tac-toe sequencer: validates moves, alternates turns, strobes the win
// detectors, and declares win/draw with a per-turn auto-move timeout.
module control_turnos
   import tictac_pkg::*;
#(
   parameter int unsigned TURN_TIMEOUT = 250_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mov_valid,
   input  logic [3:0] mov_pos,
   output logic       mov_ready,
   input  logic       gana_x,
   input  logic       gana_o,
   output logic [3:0] det_pos,
   output logic       det_we_x,
   output logic       det_we_o,
   output logic       det_rst,
   output logic [8:0] tablero_x,
   output logic [8:0] tablero_o,
   output logic       turno,
   output logic [1:0] estado_juego,
   output logic       mov_error,
   output logic       timeout
);

   estado_fsm_e state_q, state_d;
   logic [8:0]  tab_x_q, tab_x_d, tab_o_q, tab_o_d;
   logic        turno_q, turno_d;
   logic [1:0]  est_q, est_d;
   logic [3:0]  cnt_q, cnt_d, pos_q, pos_d;
   logic        we_x_q, we_x_d, we_o_q, we_o_d;
   logic        det_rst_q, det_rst_d, ready_q, ready_d;
   logic        err_q, err_d, tout_q, tout_d;

   logic [8:0]  ocupado, sel;
   logic        expira, celda_ok, mov_ok, mov_bad, gana_act;

   assign ocupado  = tab_x_q | tab_o_q;
   assign celda_ok = (mov_pos < 4'(NUM_CELDAS)) && !(|(ocupado & (9'd1 << mov_pos)));
   assign mov_ok   = mov_valid && celda_ok;
   assign mov_bad  = mov_valid && !celda_ok;
   assign gana_act = turno_q ? gana_o : gana_x;

   temporizador_turno #(
      .Limite(TURN_TIMEOUT)
   ) u_timer (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (state_q != StTurn),
      .en_i    (state_q == StTurn),
      .expira_o(expira)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StFin: if (start) state_d = StClear;
         StClear:       state_d = StTurn;
         StTurn:        if (mov_ok || expira) state_d = StApply;
         StApply:       state_d = StCheck;
         StCheck:       state_d = (gana_act || cnt_q == 4'd9) ? StFin : StTurn;
         default:       state_d = StIdle;
      endcase
   end

   // Outputs are registered, so each one is computed for the state being entered.
   always_comb begin
      tab_x_d   = tab_x_q;
      tab_o_d   = tab_o_q;
      turno_d   = turno_q;
      est_d     = est_q;
      cnt_d     = cnt_q;
      pos_d     = pos_q;
      we_x_d    = 1'b0;
      we_o_d    = 1'b0;
      err_d     = 1'b0;
      tout_d    = 1'b0;
      sel       = '0;
      det_rst_d = (state_d == StClear);
      ready_d   = (state_d == StTurn);
      unique case (state_q)
         StIdle, StFin: begin
            if (start) begin
               tab_x_d = '0;
               tab_o_d = '0;
               cnt_d   = '0;
               turno_d = 1'b0;
               est_d   = EST_JUGANDO;
            end
         end
         StTurn: begin
            err_d = mov_bad;
            if (mov_ok) begin
               pos_d = mov_pos;
            end else if (expira) begin
               pos_d  = primera_libre(ocupado);
               tout_d = 1'b1;
            end
            if (state_d == StApply) begin
               sel   = 9'd1 << pos_d;
               cnt_d = cnt_q + 4'd1;
               if (turno_q) begin
                  tab_o_d = tab_o_q | sel;
                  we_o_d  = 1'b1;
               end else begin
                  tab_x_d = tab_x_q | sel;
                  we_x_d  = 1'b1;
               end
            end
         end
         StCheck: begin
            if (gana_act)             est_d   = turno_q ? EST_GANA_O : EST_GANA_X;
            else if (cnt_q == 4'd9)   est_d   = EST_EMPATE;
            else                      turno_d = !turno_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tab_x_q   <= '0;
         tab_o_q   <= '0;
         turno_q   <= 1'b0;
         est_q     <= EST_JUGANDO;
         cnt_q     <= '0;
         pos_q     <= '0;
         we_x_q    <= 1'b0;
         we_o_q    <= 1'b0;
         det_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         tout_q    <= 1'b0;
      end else begin
         tab_x_q   <= tab_x_d;
         tab_o_q   <= tab_o_d;
         turno_q   <= turno_d;
         est_q     <= est_d;
         cnt_q     <= cnt_d;
         pos_q     <= pos_d;
         we_x_q    <= we_x_d;
         we_o_q    <= we_o_d;
         det_rst_q <= det_rst_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         tout_q    <= tout_d;
      end
   end

   assign mov_ready    = ready_q;
   assign det_pos      = pos_q;
   assign det_we_x     = we_x_q;
   assign det_we_o     = we_o_q;
   assign det_rst      = det_rst_q;
   assign tablero_x    = tab_x_q;
   assign tablero_o    = tab_o_q;
   assign turno        = turno_q;
   assign estado_juego = est_q;
   assign mov_error    = err_q;
   assign timeout      = tout_q;

endmodule

// File: tb/tb_control_turnos.sv
// Directed bench for control_turnos with a behavioural win-detector model.
module tb_control_turnos;

   localparam int unsigned TO = 8;

   logic       clk = 1'b0;
   logic       rst, start, mov_valid;
   logic [3:0] mov_pos;
   logic       mov_ready, gana_x, gana_o;
   logic [3:0] det_pos;
   logic       det_we_x, det_we_o, det_rst;
   logic [8:0] tablero_x, tablero_o;
   logic       turno;
   logic [1:0] estado_juego;
   logic       mov_error, timeout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] pos;
      logic       wex;
      logic [8:0] tx;
      logic [8:0] to;
      logic       turno;
      logic [1:0] est;
   } vec_t;

   vec_t gana_v[5];
   vec_t empate_v[9];

   control_turnos #(
      .TURN_TIMEOUT(TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .mov_valid   (mov_valid),
      .mov_pos     (mov_pos),
      .mov_ready   (mov_ready),
      .gana_x      (gana_x),
      .gana_o      (gana_o),
      .det_pos     (det_pos),
      .det_we_x    (det_we_x),
      .det_we_o    (det_we_o),
      .det_rst     (det_rst),
      .tablero_x   (tablero_x),
      .tablero_o   (tablero_o),
      .turno       (turno),
      .estado_juego(estado_juego),
      .mov_error   (mov_error),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   // Detector model: one cycle from strobe to win flag.
   logic [8:0] mb_x, mb_o;
   always @(posedge clk) begin
      if (rst || det_rst) begin
         mb_x <= '0;
         mb_o <= '0;
      end else begin
         if (det_we_x && det_pos < 4'd9) mb_x[det_pos] <= 1'b1;
         if (det_we_o && det_pos < 4'd9) mb_o[det_pos] <= 1'b1;
      end
   end

   function automatic logic tres(input logic [8:0] b);
      logic [8:0] m[8];
      m = '{9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};
      for (int i = 0; i < 8; i++) if ((b & m[i]) == m[i]) return 1'b1;
      return 1'b0;
   endfunction

   assign gana_x = tres(mb_x);
   assign gana_o = tres(mb_o);

   task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tx"}, 32'(tablero_x), 0);
      chk({tag, "_to"}, 32'(tablero_o), 0);
      chk({tag, "_turno"}, 32'(turno), 0);
      chk({tag, "_est"}, 32'(estado_juego), 0);
      chk({tag, "_det_rst"}, 32'(det_rst), 1);
      chk({tag, "_ready"}, 32'(mov_ready), 0);
      chk({tag, "_we"}, 32'({det_we_x, det_we_o}), 0);
      chk({tag, "_err_to"}, 32'({mov_error, timeout}), 0);
      chk({tag, "_pos"}, 32'(det_pos), 0);
   endtask

   task automatic esperar_listo(input string tag);
      int n = 0;
      while (!mov_ready && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_ready_wait"}, 32'(mov_ready), 1);
   endtask

   task automatic nueva_partida(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_clear_det_rst"}, 32'(det_rst), 1);
      chk({tag, "_clear_boards"}, 32'({tablero_x, tablero_o}), 0);
      tick();
      chk({tag, "_turn_ready"}, 32'(mov_ready), 1);
   endtask

   task automatic jugar(input vec_t v, input string tag);
      esperar_listo(tag);
      mov_valid = 1'b1;
      mov_pos   = v.pos;
      tick();
      mov_valid = 1'b0;
      chk({tag, "_we_x"}, 32'(det_we_x), 32'(v.wex));
      chk({tag, "_we_o"}, 32'(det_we_o), 32'(!v.wex));
      chk({tag, "_det_pos"}, 32'(det_pos), 32'(v.pos));
      tick();
      tick();
      chk({tag, "_tx"}, 32'(tablero_x), 32'(v.tx));
      chk({tag, "_to"}, 32'(tablero_o), 32'(v.to));
      chk({tag, "_turno"}, 32'(turno), 32'(v.turno));
      chk({tag, "_est"}, 32'(estado_juego), 32'(v.est));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int strobes;
      logic t_any;

      gana_v[0] = '{4'd0, 1'b1, 9'h001, 9'h000, 1'b1, 2'b00};
      gana_v[1] = '{4'd3, 1'b0, 9'h001, 9'h008, 1'b0, 2'b00};
      gana_v[2] = '{4'd1, 1'b1, 9'h003, 9'h008, 1'b1, 2'b00};
      gana_v[3] = '{4'd4, 1'b0, 9'h003, 9'h018, 1'b0, 2'b00};
      gana_v[4] = '{4'd2, 1'b1, 9'h007, 9'h018, 1'b0, 2'b01};

      empate_v[0] = '{4'd0, 1'b1, 9'h001, 9'h000, 1'b1, 2'b00};
      empate_v[1] = '{4'd1, 1'b0, 9'h001, 9'h002, 1'b0, 2'b00};
      empate_v[2] = '{4'd2, 1'b1, 9'h005, 9'h002, 1'b1, 2'b00};
      empate_v[3] = '{4'd4, 1'b0, 9'h005, 9'h012, 1'b0, 2'b00};
      empate_v[4] = '{4'd3, 1'b1, 9'h00D, 9'h012, 1'b1, 2'b00};
      empate_v[5] = '{4'd5, 1'b0, 9'h00D, 9'h032, 1'b0, 2'b00};
      empate_v[6] = '{4'd7, 1'b1, 9'h08D, 9'h032, 1'b1, 2'b00};
      empate_v[7] = '{4'd6, 1'b0, 9'h08D, 9'h072, 1'b0, 2'b00};
      empate_v[8] = '{4'd8, 1'b1, 9'h18D, 9'h072, 1'b0, 2'b11};

      rst = 1'b1; start = 1'b0; mov_valid = 1'b0; mov_pos = '0;
      tick();
      tick();
      chk_reset("por");
      rst = 1'b0;
      tick();
      chk("idle_det_rst", 32'(det_rst), 0);
      chk("idle_ready", 32'(mov_ready), 0);

      // Win on row 0
      nueva_partida("win");
      for (int i = 0; i < 5; i++) jugar(gana_v[i], $sformatf("win%0d", i));
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         strobes += int'(det_we_x) + int'(det_we_o);
      end
      chk("win_no_strobes", 32'(strobes), 0);
      chk("win_fin_ready", 32'(mov_ready), 0);
      mov_valid = 1'b1; mov_pos = 4'd9;
      tick();
      tick();
      mov_valid = 1'b0;
      chk("fin_no_err", 32'(mov_error), 0);
      chk("fin_hold_tx", 32'(tablero_x), 32'h007);

      // Draw
      nueva_partida("draw");
      for (int i = 0; i < 9; i++) jugar(empate_v[i], $sformatf("draw%0d", i));
      chk("draw_cnt", 32'(dut.cnt_q), 9);

      // Invalid moves, then O times out onto cell 0
      nueva_partida("inv");
      jugar('{4'd4, 1'b1, 9'h010, 9'h000, 1'b1, 2'b00}, "inv_x4");
      mov_valid = 1'b1; mov_pos = 4'd4;
      tick();
      chk("inv_err_occ", 32'(mov_error), 1);
      mov_pos = 4'd9;
      tick();
      chk("inv_err_range", 32'(mov_error), 1);
      chk("inv_to_unchanged", 32'(tablero_o), 0);
      chk("inv_turno", 32'(turno), 1);
      mov_valid = 1'b0;
      tick();
      chk("inv_err_clear", 32'(mov_error), 0);
      t_any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         t_any |= timeout;
      end
      chk("inv_no_early_timeout", 32'(t_any), 0);
      tick();
      chk("inv_timeout", 32'(timeout), 1);
      chk("inv_auto_to", 32'(tablero_o), 32'h001);
      chk("inv_auto_we_o", 32'(det_we_o), 1);
      tick();
      tick();
      chk("inv_turno_back", 32'(turno), 0);

      // Timeout with cells 0 and 1 taken: X is auto-played on cell 2
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      nueva_partida("tmo");
      jugar('{4'd0, 1'b1, 9'h001, 9'h000, 1'b1, 2'b00}, "tmo_x0");
      jugar('{4'd1, 1'b0, 9'h001, 9'h002, 1'b0, 2'b00}, "tmo_o1");
      t_any = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         t_any |= timeout;
      end
      chk("tmo_no_early", 32'(t_any), 0);
      chk("tmo_still_turn", 32'(mov_ready), 1);
      tick();
      chk("tmo_pulse", 32'(timeout), 1);
      chk("tmo_cell2", 32'(tablero_x), 32'h005);
      chk("tmo_det_pos", 32'(det_pos), 2);
      tick();
      chk("tmo_one_cycle", 32'(timeout), 0);
      tick();
      chk("tmo_turno", 32'(turno), 1);

      // Valid move on the expiry cycle, then reset during APPLY
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      nueva_partida("edge");
      for (int i = 0; i < 7; i++) tick();
      mov_valid = 1'b1; mov_pos = 4'd5;
      tick();
      mov_valid = 1'b0;
      chk("edge_no_timeout", 32'(timeout), 0);
      chk("edge_player_cell", 32'(tablero_x), 32'h020);
      rst = 1'b1;
      tick();
      chk_reset("apply_rst");
      rst = 1'b0;
      tick();
      tick();
      tick();
      chk("rst_needs_start", 32'(mov_ready), 0);
      nueva_partida("resume");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
